// File: rtl/keynsham_icache_pkg.sv
// Shared definitions for the keynsham instruction cache: geometry defaults,
// the NOP encoding and the cache controller state encoding.
package keynsham_icache_pkg;

    localparam int          KEYNSHAM_ICACHE_LINES      = 32;
    localparam int          KEYNSHAM_ICACHE_LINE_WORDS = 8;
    localparam logic [31:0] INSTR_NOP                  = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/keynsham_icache_mem.sv
// Synchronous 1R/1W RAM used for both the tag and the data arrays.
// Read data appears the cycle after the address is presented.
module keynsham_icache_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/keynsham_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, whole-line fills
// from the backing bus in ascending word order on a miss.
module keynsham_icache
    import keynsham_icache_pkg::*;
#(
    parameter int NUM_LINES  = KEYNSHAM_ICACHE_LINES,
    parameter int LINE_WORDS = KEYNSHAM_ICACHE_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_access,
    input  logic [29:0] c_addr,
    output logic [31:0] c_data,
    output logic        c_ack,
    output logic        c_error,
    output logic        m_access,
    output logic [29:0] m_addr,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error,
    input  logic        inv
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = 30 - OFF_BITS - IDX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

    state_t                state_q, state_d;
    logic [29:0]           addr_q;
    logic [OFF_BITS-1:0]   cnt_q;
    logic [31:0]           ret_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic                  inv_seen_q;

    logic [OFF_BITS-1:0]   off_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic [TAG_BITS-1:0]   tag_rd;
    logic [31:0]           data_rd;
    logic                  hit;
    logic                  fill_ok;

    assign off_q   = addr_q[OFF_BITS-1:0];
    assign idx_q   = addr_q[OFF_BITS +: IDX_BITS];
    assign tag_q   = addr_q[29 -: TAG_BITS];
    assign hit     = valid_q[idx_q] && (tag_rd == tag_q);
    assign fill_ok = (state_q == FILL_WAIT) && m_ack && !m_error;

    // Arrays are read every cycle straight from c_addr, so in LOOKUP the
    // read data corresponds to the address sampled with c_access.
    keynsham_icache_mem #(.DEPTH(NUM_LINES), .WIDTH(TAG_BITS)) u_tags (
        .clk    (clk),
        .rd_addr(c_addr[OFF_BITS +: IDX_BITS]),
        .rd_data(tag_rd),
        .wr_en  (state_q == DONE),
        .wr_addr(idx_q),
        .wr_data(tag_q)
    );

    keynsham_icache_mem #(.DEPTH(NUM_LINES * LINE_WORDS), .WIDTH(32)) u_data (
        .clk    (clk),
        .rd_addr(c_addr[OFF_BITS + IDX_BITS - 1:0]),
        .rd_data(data_rd),
        .wr_en  (fill_ok),
        .wr_addr({idx_q, cnt_q}),
        .wr_data(m_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        c_ack    = 1'b0;
        c_error  = 1'b0;
        c_data   = 32'h0;
        m_access = 1'b0;
        m_addr   = 30'h0;
        case (state_q)
            IDLE:      if (c_access) state_d = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    c_ack   = 1'b1;
                    c_data  = data_rd;
                    state_d = IDLE;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                m_access = 1'b1;
                m_addr   = {tag_q, idx_q, cnt_q};
                state_d  = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (m_ack) begin
                    if (m_error)
                        state_d = ERR;
                    else if (cnt_q == LAST_WORD)
                        state_d = DONE;
                    else
                        state_d = FILL_REQ;
                end
            end
            DONE: begin
                c_ack   = 1'b1;
                c_data  = ret_q;
                state_d = IDLE;
            end
            ERR: begin
                c_ack   = 1'b1;
                c_error = 1'b1;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= 30'h0;
            cnt_q      <= '0;
            ret_q      <= 32'h0;
            valid_q    <= '0;
            inv_seen_q <= 1'b0;
        end else begin
            if (state_q == IDLE && c_access)
                addr_q <= c_addr;

            if (state_q == LOOKUP && !hit)
                cnt_q <= '0;
            else if (fill_ok && cnt_q != LAST_WORD)
                cnt_q <= cnt_q + 1'b1;

            if (fill_ok && cnt_q == off_q)
                ret_q <= m_data;

            // The victim line is dropped at miss time since its data is
            // overwritten word by word; an invalidate always takes priority.
            if (inv)
                valid_q <= '0;
            else if (state_q == LOOKUP && !hit)
                valid_q[idx_q] <= 1'b0;
            else if (state_q == DONE && !inv_seen_q)
                valid_q[idx_q] <= 1'b1;

            if (state_q == LOOKUP && !hit)
                inv_seen_q <= inv;
            else if (inv)
                inv_seen_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keynsham_icache.sv
// Scoreboard bench for keynsham_icache with a word=address backing memory
// model that supports configurable latency and a single error address.
module tb_keynsham_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_access = 1'b0;
    logic [29:0] c_addr = 30'h0;
    logic [31:0] c_data;
    logic        c_ack;
    logic        c_error;
    logic        m_access;
    logic [29:0] m_addr;
    logic [31:0] m_data = 32'h0;
    logic        m_ack = 1'b0;
    logic        m_error = 1'b0;
    logic        inv = 1'b0;

    keynsham_icache dut (
        .clk     (clk),
        .rst     (rst),
        .c_access(c_access),
        .c_addr  (c_addr),
        .c_data  (c_data),
        .c_ack   (c_ack),
        .c_error (c_error),
        .m_access(m_access),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .m_ack   (m_ack),
        .m_error (m_error),
        .inv     (inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          n_ack = 0;
    int          n_macc = 0;
    logic [29:0] maddr_log[$];
    int          mem_lat = 1;
    logic        err_en = 1'b0;
    logic [29:0] err_addr = 30'h0;
    int          pend = 0;
    logic [29:0] pend_addr = 30'h0;

    // Backing memory: returns word = address after mem_lat negedges.
    always @(negedge clk) begin
        m_ack   = 1'b0;
        m_error = 1'b0;
        m_data  = 32'h0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                m_ack   = 1'b1;
                m_data  = {2'b00, pend_addr};
                m_error = err_en && (pend_addr == err_addr);
            end
        end
        if (m_access) begin
            pend_addr = m_addr;
            pend      = mem_lat;
            n_macc++;
            maddr_log.push_back(m_addr);
        end
    end

    // Scoreboard: every ack pops one expectation; idle cycles must show zero data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (c_ack) begin
                n_ack++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got data %h err %b, want no ack", c_data, c_error);
                end else begin
                    e = sb.pop_front();
                    if (c_data !== e.data || c_error !== e.err) begin
                        errors++;
                        $display("FAIL ack_result: got data %h err %b, want data %h err %b",
                                 c_data, c_error, e.data, e.err);
                    end
                end
            end else if (c_data !== 32'h0 || c_error !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: got data %h err %b, want 0 0", c_data, c_error);
            end
        end
    end

    task automatic start_fetch(input logic [29:0] a, input logic with_inv, input logic expect_ack,
                               input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(negedge clk);
        if (expect_ack) begin
            e.data = exp_data;
            e.err  = exp_err;
            sb.push_back(e);
        end
        c_addr   = a;
        c_access = 1'b1;
        inv      = with_inv;
        @(posedge clk);
        #1;
        c_access = 1'b0;
        inv      = 1'b0;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (c_ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack in 200 cycles, want ack");
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (c_ack !== 1'b0 || c_error !== 1'b0 || c_data !== 32'h0 || m_access !== 1'b0 || m_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack %b err %b data %h macc %b maddr %h, want all 0",
                     c_ack, c_error, c_data, m_access, m_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cold_miss_then_hit();
        int lat, b, q0;
        b  = n_macc;
        q0 = maddr_log.size();
        start_fetch(30'h0800_0003, 1'b0, 1'b1, 32'h0800_0003, 1'b0);
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 8) begin
            errors++;
            $display("FAIL cold_fill_count: got %0d m_access, want 8", n_macc - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (maddr_log[q0 + i] !== 30'h0800_0000 + 30'(i)) begin
                    errors++;
                    $display("FAIL fill_addr[%0d]: got %h want %h", i, maddr_log[q0 + i], 30'h0800_0000 + 30'(i));
                end
            end
        end
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL miss_latency: got %0d cycles, want 18", lat);
        end
        b = n_macc;
        start_fetch(30'h0800_0005, 1'b0, 1'b1, 32'h0800_0005, 1'b0);
        wait_ack(lat);
        checks++;
        if (lat !== 1 || n_macc - b !== 0) begin
            errors++;
            $display("FAIL hit: got latency %0d m_access %0d, want 1 and 0", lat, n_macc - b);
        end
    endtask

    task automatic test_conflict();
        logic [29:0] addrs [3];
        int lat, b;
        addrs[0] = 30'h0800_0000;
        addrs[1] = 30'h0800_0100;
        addrs[2] = 30'h0800_0000;
        @(negedge clk);
        inv = 1'b1;
        @(posedge clk);
        #1 inv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = n_macc;
            start_fetch(addrs[i], 1'b0, 1'b1, {2'b00, addrs[i]}, 1'b0);
            wait_ack(lat);
            checks++;
            if (n_macc - b !== 8) begin
                errors++;
                $display("FAIL conflict_fill[%0d]: got %0d m_access, want 8", i, n_macc - b);
            end
        end
    endtask

    task automatic test_fill_error();
        int lat, b;
        err_en   = 1'b1;
        err_addr = 30'h0800_0014;
        b = n_macc;
        start_fetch(30'h0800_0010, 1'b0, 1'b1, 32'h0, 1'b1);
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 5) begin
            errors++;
            $display("FAIL error_fill_count: got %0d m_access, want 5", n_macc - b);
        end
        err_en = 1'b0;
        b = n_macc;
        start_fetch(30'h0800_0010, 1'b0, 1'b1, 32'h0800_0010, 1'b0);
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 8) begin
            errors++;
            $display("FAIL error_refetch: got %0d m_access, want 8", n_macc - b);
        end
    endtask

    task automatic test_inv_mid_fill();
        int lat, b;
        b = n_macc;
        start_fetch(30'h0800_0020, 1'b0, 1'b1, 32'h0800_0020, 1'b0);
        repeat (6) @(negedge clk);
        inv = 1'b1;
        @(posedge clk);
        #1 inv = 1'b0;
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 8) begin
            errors++;
            $display("FAIL inv_fill_count: got %0d m_access, want 8", n_macc - b);
        end
        b = n_macc;
        start_fetch(30'h0800_0020, 1'b0, 1'b1, 32'h0800_0020, 1'b0);
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 8) begin
            errors++;
            $display("FAIL inv_refetch: got %0d m_access, want 8 (miss)", n_macc - b);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat, b, acks;
        mem_lat = 3;
        start_fetch(30'h0800_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (c_ack !== 1'b0 || c_error !== 1'b0 || c_data !== 32'h0 || m_access !== 1'b0 || m_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_mid_fill: got ack %b err %b data %h macc %b maddr %h, want all 0",
                     c_ack, c_error, c_data, m_access, m_addr);
        end
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        acks = n_ack;
        repeat (10) @(negedge clk);
        checks++;
        if (n_ack !== acks) begin
            errors++;
            $display("FAIL abandoned_ack: got %0d acks, want 0", n_ack - acks);
        end
        mem_lat = 1;
        b = n_macc;
        start_fetch(30'h0800_0000, 1'b0, 1'b1, 32'h0800_0000, 1'b0);
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 8 || lat !== 18) begin
            errors++;
            $display("FAIL post_reset_fill: got %0d m_access latency %0d, want 8 and 18", n_macc - b, lat);
        end
    endtask

    task automatic test_inv_with_access();
        int lat, b;
        b = n_macc;
        start_fetch(30'h0800_0006, 1'b0, 1'b1, 32'h0800_0006, 1'b0);
        wait_ack(lat);
        checks++;
        if (lat !== 1 || n_macc - b !== 0) begin
            errors++;
            $display("FAIL prefill_hit: got latency %0d m_access %0d, want 1 and 0", lat, n_macc - b);
        end
        b = n_macc;
        start_fetch(30'h0800_0006, 1'b1, 1'b1, 32'h0800_0006, 1'b0);
        wait_ack(lat);
        checks++;
        if (n_macc - b !== 8 || lat !== 18) begin
            errors++;
            $display("FAIL inv_access: got %0d m_access latency %0d, want 8 and 18", n_macc - b, lat);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_then_hit();
        test_conflict();
        test_fill_error();
        test_inv_mid_fill();
        test_reset_mid_fill();
        test_inv_with_access();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish by 500000, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keynsham_icache.md
Name: keynsham_icache

Overview:
- Direct-mapped, read-only instruction cache between the oldland_cpu instruction port and the SDRAM instruction port in keynsham_soc.
- Hits return in one cycle.
- Misses fill a whole line from the backing bus, word by word, then answer the CPU.
- Handles only the cacheable SDRAM window; the SoC decode routes other instruction addresses around it.

Parameters:
- NUM_LINES, 32, number of cache lines; power of two, at least 2.
- LINE_WORDS, 8, 32-bit words per line; power of two, at least 2.
- Derived: OFF_BITS = log2(LINE_WORDS), IDX_BITS = log2(NUM_LINES), TAG_BITS = 30 - OFF_BITS - IDX_BITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- c_access  in  1  CPU fetch request, one-cycle pulse.
- c_addr  in  30  CPU word address, sampled when c_access=1.
- c_data  out  32  fetched instruction, valid while c_ack=1.
- c_ack  out  1  fetch complete, one-cycle pulse.
- c_error  out  1  fetch failed, coincident with c_ack.
- m_access  out  1  backing-bus read request, one-cycle pulse.
- m_addr  out  30  backing-bus word address.
- m_data  in  32  backing-bus read data, valid with m_ack.
- m_ack  in  1  backing-bus completion pulse.
- m_error  in  1  backing-bus error, coincident with m_ack.
- inv  in  1  invalidate all lines, one-cycle pulse.

Behaviour:
- Reset (async, active-high):
  - All outputs 0.
  - All valid bits cleared.
  - FSM goes to IDLE.
  - Reset mid-fill abandons the fill; no ack is ever issued for that request.
- Address split: offset = c_addr[OFF_BITS-1:0], index = next IDX_BITS bits, tag = upper TAG_BITS bits.
- Storage:
  - Valid bits are flops.
  - Tag and data arrays are synchronous RAM, one read port and one write port.
- CPU protocol: the CPU issues no new c_access until c_ack for the previous one. The cache latches c_addr on c_access.
- FSM:
  - IDLE: on c_access, latch the address and issue tag/data reads → LOOKUP.
  - LOOKUP, hit (valid[index] and tag match): c_ack=1 and c_data = array word in this cycle → IDLE. Hit latency is therefore exactly 1 cycle after c_access.
  - LOOKUP, miss: word counter = 0 → FILL_REQ.
  - FILL_REQ: m_access=1 for one cycle, m_addr = {tag, index, counter} → FILL_WAIT.
  - FILL_WAIT, m_ack && !m_error: write m_data to data[index][counter]. If counter == offset, also capture it in a return register. If counter == LINE_WORDS-1 → DONE, else counter+1 → FILL_REQ.
  - FILL_WAIT, m_ack && m_error: abort fill; valid[index] stays 0 → ERR.
  - DONE: write tag; set valid[index] unless an inv arrived during the fill; c_ack=1, c_data = return register → IDLE.
  - ERR: c_ack=1, c_error=1, c_data=0 → IDLE.
- Miss latency: 2 + sum over LINE_WORDS of (1 + backing latency) cycles. Fill order is always offset 0 upward; there is no critical-word-first.
- c_data is 0 whenever c_ack=0.
- inv:
  - Clears all valid bits in the cycle it is sampled, in any state.
  - inv together with c_access in IDLE: the invalidate wins and the lookup misses.
  - inv during a fill: the in-flight request still completes with the fetched data, but the line is not marked valid.
- Wrap-around: the counter runs from 0 to LINE_WORDS-1 only, and m_addr never crosses the line base.
- Stale m_ack outside FILL_WAIT is ignored.

Decomposition:
- Shared defines include (alongside INSTR_NOP):
  - KEYNSHAM_ICACHE_LINES and KEYNSHAM_ICACHE_LINE_WORDS defaults.
  - FSM state encodings: IDLE, LOOKUP, FILL_REQ, FILL_WAIT, DONE, ERR.
- Sub-module keynsham_icache_mem: parameterised synchronous dual-port (1R/1W) RAM, instantiated once for tags (NUM_LINES x TAG_BITS) and once for data (NUM_LINES*LINE_WORDS x 32).
- Valid bits and the FSM stay in keynsham_icache.

Test Plan:
- Cold miss, then hit:
  - Stimulus: backing memory word = address; fetch 0x08000003; then fetch 0x08000005.
  - First fetch: m_addr sequence 0x08000000..0x08000007, then c_ack with c_data=0x08000003.
  - Second fetch: c_ack exactly 1 cycle after c_access, c_data=0x08000005, no m_access.
- Conflict eviction: fetch 0x08000000, then 0x08000100 (same index, new tag), then 0x08000000 → all three miss, 3 full fills.
- Fill error: m_error on word 4 of a fill for 0x08000010 → c_ack=1, c_error=1, c_data=0; refetching the same address misses again.
- inv mid-fill: pulse inv during word 2 of a fill for 0x08000020 → CPU still receives the correct word; the next fetch of 0x08000020 misses.
- Reset mid-fill: assert rst during FILL_WAIT → outputs 0 at once, no c_ack; after release, fetch 0x08000000 performs a full fill.
- Simultaneous inv and c_access on a previously valid line → lookup misses and refills.
